status_vector_reader: RTL and testbench

STATUS_VECTOR_READER -- requirements
Module: status_vector_reader

---
 rtl/status_vector_reader.sv | 133 +++++++++++++
 tb/tb_status_vector_reader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/status_vector_reader.sv
// Drains a status vector one entry at a time into a 2-entry skid FIFO with a valid/ready output.
// Optional discard mode (flush_i port, FLUSH state) is compiled in with STATUS_READER_FLUSH_EN.
module status_vector_reader #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rsn_i,
  input  logic             vec_valid_i,
  input  logic [WIDTH-1:0] vec_value_i,
  input  logic             vec_full_i,
  output logic             vec_pull_o,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             full_seen_o,
  input  logic             clear_i,
  output logic [CNT_W-1:0] count_o
`ifdef STATUS_READER_FLUSH_EN
  ,
  input  logic             flush_i
`endif
);

`ifdef STATUS_READER_FLUSH_EN
  typedef enum logic [1:0] {StIdle, StStream, StFlush} state_e;
`else
  typedef enum logic [1:0] {StIdle, StStream} state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       occ_q, occ_d;
  logic [CNT_W-1:0] count_q;
  logic             full_seen_q;
  logic             flush;
  logic             pull;
  logic             store;
  logic             xfer;

`ifdef STATUS_READER_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  always_comb begin
    xfer = (occ_q != 2'd0) && ready_i;
    pull = 1'b0;
    case (state_q)
      StStream: pull = vec_valid_i && ((occ_q != 2'd2) || xfer);
`ifdef STATUS_READER_FLUSH_EN
      StFlush:  pull = vec_valid_i;
`endif
      default:  pull = 1'b0;
    endcase
    // Entries pulled in FLUSH, or on the edge that enters it, are dropped.
    store = pull && (state_q == StStream) && !flush;

    occ_d = occ_q;
    if (flush) begin
      occ_d = 2'd0;
    end else if (store && !xfer) begin
      occ_d = occ_q + 2'd1;
    end else if (!store && xfer) begin
      occ_d = occ_q - 2'd1;
    end

    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (vec_valid_i || (occ_q != 2'd0)) state_d = StStream;
      end
      StStream: begin
        if (!vec_valid_i && (occ_d == 2'd0)) state_d = StIdle;
      end
`ifdef STATUS_READER_FLUSH_EN
      StFlush: begin
        if (!flush_i && !vec_valid_i) state_d = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
`ifdef STATUS_READER_FLUSH_EN
    if (flush_i) state_d = StFlush;
`endif
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q     <= StIdle;
      occ_q       <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
      count_q     <= '0;
      full_seen_q <= 1'b0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      if (flush) begin
        wr_ptr_q <= 1'b0;
        rd_ptr_q <= 1'b0;
      end else begin
        if (store) begin
          mem_q[wr_ptr_q] <= vec_value_i;
          wr_ptr_q        <= ~wr_ptr_q;
        end
        if (xfer) rd_ptr_q <= ~rd_ptr_q;
      end
      // Clear has priority over both increment and the full flag set.
      if (clear_i) begin
        count_q <= '0;
      end else if (xfer && (count_q != {CNT_W{1'b1}})) begin
        count_q <= count_q + 1'b1;
      end
      if (clear_i) begin
        full_seen_q <= 1'b0;
      end else if (vec_full_i) begin
        full_seen_q <= 1'b1;
      end
    end
  end

  assign vec_pull_o  = pull;
  assign valid_o     = (occ_q != 2'd0);
  assign data_o      = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o     = count_q;
  assign full_seen_o = full_seen_q;

endmodule

// File: tb/tb_status_vector_reader.sv
// Directed table-driven bench for status_vector_reader; flush checks run when
// STATUS_READER_FLUSH_EN is defined.
module tb_status_vector_reader;

  logic       clk = 1'b0;
  logic       rsn;
  logic       vec_valid;
  logic [3:0] vec_value;
  logic       vec_full;
  logic       ready;
  logic       clear;
  logic       flush;
  logic       vec_pull;
  logic [3:0] data;
  logic       valid;
  logic       full_seen;
  logic [15:0] count;
  logic       vec_pull2;
  logic [3:0] data2;
  logic       valid2;
  logic       full_seen2;
  logic [1:0] count2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  status_vector_reader dut (
    .clk_i      (clk),
    .rsn_i      (rsn),
    .vec_valid_i(vec_valid),
    .vec_value_i(vec_value),
    .vec_full_i (vec_full),
    .vec_pull_o (vec_pull),
    .data_o     (data),
    .valid_o    (valid),
    .ready_i    (ready),
    .full_seen_o(full_seen),
    .clear_i    (clear),
    .count_o    (count)
`ifdef STATUS_READER_FLUSH_EN
    ,
    .flush_i    (flush)
`endif
  );

  status_vector_reader #(.WIDTH(4), .CNT_W(2)) dut_sat (
    .clk_i      (clk),
    .rsn_i      (rsn),
    .vec_valid_i(vec_valid),
    .vec_value_i(vec_value),
    .vec_full_i (vec_full),
    .vec_pull_o (vec_pull2),
    .data_o     (data2),
    .valid_o    (valid2),
    .ready_i    (ready),
    .full_seen_o(full_seen2),
    .clear_i    (clear),
    .count_o    (count2)
`ifdef STATUS_READER_FLUSH_EN
    ,
    .flush_i    (flush)
`endif
  );

  typedef struct {
    logic       vv;
    logic [3:0] val;
    logic       full;
    logic       rdy;
    logic       clr;
    logic       e_pull;
    logic       e_valid;
    logic [3:0] e_data;
    int         e_cnt;
    logic       e_fs;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic vv, input int val, input logic full, input logic rdy,
                     input logic clr, input logic e_pull, input logic e_valid, input int e_data,
                     input int e_cnt, input logic e_fs);
    vec_t v;
    v.vv = vv; v.val = val[3:0]; v.full = full; v.rdy = rdy; v.clr = clr;
    v.e_pull = e_pull; v.e_valid = e_valid; v.e_data = e_data[3:0];
    v.e_cnt = e_cnt; v.e_fs = e_fs;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int remaining;
    int n_pulls;
    logic pulled;

    rsn = 1'b0; vec_valid = 1'b0; vec_value = '0; vec_full = 1'b0;
    ready = 1'b0; clear = 1'b0; flush = 1'b0;
    #2;
    check("reset valid", valid, 0);
    check("reset data", data, 0);
    check("reset pull", vec_pull, 0);
    check("reset count", count, 0);
    check("reset full_seen", full_seen, 0);
    check("reset count sat", count2, 0);
    @(negedge clk);
    @(negedge clk);
    rsn = 1'b1;

    //  vv val full rdy clr | pull valid data cnt fs
    add(1, 1,  0, 1, 0,   0, 0, 0,  0, 0);
    add(1, 1,  0, 1, 0,   1, 0, 0,  0, 0);
    add(1, 2,  0, 1, 0,   1, 1, 1,  0, 0);
    add(1, 3,  0, 1, 0,   1, 1, 2,  1, 0);
    add(1, 4,  0, 1, 0,   1, 1, 3,  2, 0);
    add(0, 0,  0, 1, 0,   0, 1, 4,  3, 0);
    add(0, 0,  0, 0, 0,   0, 0, 0,  4, 0);
    add(1, 5,  0, 0, 0,   0, 0, 0,  4, 0);
    add(1, 5,  0, 0, 0,   1, 0, 0,  4, 0);
    add(1, 6,  0, 0, 0,   1, 1, 5,  4, 0);
    add(1, 7,  0, 0, 0,   0, 1, 5,  4, 0);
    add(1, 7,  0, 0, 0,   0, 1, 5,  4, 0);
    add(1, 7,  0, 1, 0,   1, 1, 5,  4, 0);
    add(0, 0,  0, 1, 0,   0, 1, 6,  5, 0);
    add(0, 0,  0, 1, 0,   0, 1, 7,  6, 0);
    add(0, 0,  0, 0, 0,   0, 0, 0,  7, 0);
    add(0, 0,  1, 0, 0,   0, 0, 0,  7, 0);
    add(0, 0,  0, 0, 0,   0, 0, 0,  7, 1);
    add(1, 9,  0, 0, 0,   0, 0, 0,  7, 1);
    add(1, 9,  0, 0, 0,   1, 0, 0,  7, 1);
    add(0, 0,  1, 1, 1,   0, 1, 9,  7, 1);
    add(0, 0,  0, 0, 0,   0, 0, 0,  0, 0);
    add(1, 10, 0, 0, 0,   0, 0, 0,  0, 0);
    add(1, 10, 0, 0, 0,   1, 0, 0,  0, 0);
    add(0, 0,  0, 0, 1,   0, 1, 10, 0, 0);
    add(0, 0,  0, 1, 0,   0, 1, 10, 0, 0);
    add(0, 0,  0, 0, 0,   0, 0, 0,  1, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      tick();
      vec_valid = tbl[i].vv; vec_value = tbl[i].val; vec_full = tbl[i].full;
      ready = tbl[i].rdy; clear = tbl[i].clr;
      @(negedge clk);
      check($sformatf("row%0d pull", i), vec_pull, tbl[i].e_pull);
      check($sformatf("row%0d valid", i), valid, tbl[i].e_valid);
      if (tbl[i].e_valid) check($sformatf("row%0d data", i), data, tbl[i].e_data);
      check($sformatf("row%0d count", i), count, tbl[i].e_cnt);
      check($sformatf("row%0d full_seen", i), full_seen, tbl[i].e_fs);
      check($sformatf("row%0d count sat", i), count2, (tbl[i].e_cnt > 3) ? 3 : tbl[i].e_cnt);
    end

    // Fill to occ=2, then assert reset mid-cycle.
    tick(); vec_valid = 1'b1; vec_value = 4'd1; ready = 1'b0; vec_full = 1'b0; clear = 1'b0;
    tick();
    tick(); vec_value = 4'd2;
    tick(); vec_valid = 1'b0;
    @(negedge clk);
    check("pre-reset valid", valid, 1);
    check("pre-reset data", data, 1);
    #2 rsn = 1'b0;
    #1;
    check("async reset valid", valid, 0);
    check("async reset data", data, 0);
    check("async reset pull", vec_pull, 0);
    check("async reset count", count, 0);
    @(negedge clk);
    rsn = 1'b1;
    @(negedge clk);
    check("post-reset valid", valid, 0);
    tick(); vec_valid = 1'b1; vec_value = 4'd12; ready = 1'b1;
    @(negedge clk);
    check("post-reset idle pull", vec_pull, 0);
    tick();
    @(negedge clk);
    check("post-reset first pull", vec_pull, 1);
    tick(); vec_valid = 1'b0;
    @(negedge clk);
    check("post-reset valid new", valid, 1);
    check("post-reset data new", data, 12);
    tick();
    @(negedge clk);
    check("post-reset count", count, 1);
    check("post-reset empty", valid, 0);

`ifdef STATUS_READER_FLUSH_EN
    // occ=2 plus three more entries waiting; flush must drain and drop all of them.
    tick(); vec_valid = 1'b1; vec_value = 4'd1; ready = 1'b0;
    tick();
    tick(); vec_value = 4'd2;
    tick(); vec_value = 4'd3;
    @(negedge clk);
    check("flush pre valid", valid, 1);
    check("flush pre pull", vec_pull, 0);
    flush = 1'b1;
    tick(); flush = 1'b0;
    remaining = 3;
    n_pulls = 0;
    for (int k = 0; k < 8 && remaining > 0; k++) begin
      @(negedge clk);
      check($sformatf("flush valid %0d", k), valid, 0);
      pulled = vec_pull;
      if (pulled) n_pulls++;
      tick();
      if (pulled) begin
        remaining--;
        vec_value = vec_value + 4'd1;
        if (remaining == 0) vec_valid = 1'b0;
      end
    end
    check("flush pulls", n_pulls, 3);
    @(negedge clk);
    check("flush count", count, 1);
    check("flush tail pull", vec_pull, 0);
    tick(); vec_valid = 1'b1; vec_value = 4'd7;
    @(negedge clk);
    check("flush idle pull", vec_pull, 0);
    tick();
    @(negedge clk);
    check("flush restream pull", vec_pull, 1);
    tick(); vec_valid = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
